// File: rtl/config_msg_arbiter_if.sv
// Val/rdy bundle between the config message sources and the arbiter, plus the
// arbiter's single output channel toward the configuration register chain.
interface config_msg_arbiter_if #(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_SIZE    = 4,
    parameter int PAYLOAD_SIZE = 8
);
    localparam int MSG_W = ADDR_SIZE + PAYLOAD_SIZE + 1;
    localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Handshake: a transfer happens on a rising edge where val && rdy are both 1.
    // A source holds val and its message stable until that edge; rdy may depend on val.
    logic [NUM_REQ-1:0]       recv_val;
    logic [NUM_REQ-1:0]       recv_rdy;
    logic [NUM_REQ*MSG_W-1:0] recv_msg;
    logic                     send_val;
    logic                     send_rdy;
    logic [MSG_W-1:0]         send_msg;
    logic [SRC_W-1:0]         send_src;

    modport master (
        output recv_val, recv_msg, send_rdy,
        input  recv_rdy, send_val, send_msg, send_src
    );

    modport slave (
        input  recv_val, recv_msg, send_rdy,
        output recv_rdy, send_val, send_msg, send_src
    );
endinterface

// File: rtl/config_msg_arbiter.sv
// Round-robin arbiter feeding a one-entry buffer on the config message channel.
// Define CONFIG_MSG_ARBITER_FIXED_PRIO_EN for fixed priority (index 0 wins, no pointer).
module config_msg_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_SIZE    = 4,
    parameter int PAYLOAD_SIZE = 8
) (
    input  logic                                        clk,
    input  logic                                        reset,
    config_msg_arbiter_if.slave                         bus,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] o_dbg_ptr
);
    localparam int MSG_W = ADDR_SIZE + PAYLOAD_SIZE + 1;
    localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic               r_full;
    logic [MSG_W-1:0]   r_msg;
    logic [SRC_W-1:0]   r_src;

    logic [SRC_W-1:0]   w_start;
    logic [SRC_W:0]     w_cand;
    logic [SRC_W-1:0]   w_gnt_idx;
    logic               w_gnt_any;
    logic               w_space;
    logic               w_accept;

`ifdef CONFIG_MSG_ARBITER_FIXED_PRIO_EN
    assign w_start   = '0;
    assign o_dbg_ptr = '0;
`else
    logic [SRC_W-1:0]   r_ptr;

    assign w_start   = r_ptr;
    assign o_dbg_ptr = r_ptr;

    // Pointer moves only on accept, to one past the winner with an explicit wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            if (w_gnt_idx == SRC_W'(NUM_REQ - 1))
                r_ptr <= '0;
            else
                r_ptr <= w_gnt_idx + SRC_W'(1);
        end
    end
`endif

    // Circular search from w_start; the candidate is reduced explicitly so
    // non-power-of-two requester counts wrap correctly.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = {1'b0, w_start} + (SRC_W+1)'(k);
            if (w_cand >= (SRC_W+1)'(NUM_REQ))
                w_cand = w_cand - (SRC_W+1)'(NUM_REQ);
            if (!w_gnt_any && bus.recv_val[w_cand[SRC_W-1:0]]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = w_cand[SRC_W-1:0];
            end
        end
    end

    assign w_space  = !r_full || bus.send_rdy;
    // Gating with reset keeps every ready low while reset is held, even though
    // the cleared buffer would otherwise report space.
    assign w_accept = reset && w_space && w_gnt_any;

    always_comb begin
        bus.recv_rdy = '0;
        if (w_accept)
            bus.recv_rdy[w_gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_full <= 1'b0;
            r_msg  <= '0;
            r_src  <= '0;
        end else if (w_accept) begin
            r_full <= 1'b1;
            r_msg  <= bus.recv_msg[w_gnt_idx*MSG_W +: MSG_W];
            r_src  <= w_gnt_idx;
        end else if (r_full && bus.send_rdy) begin
            r_full <= 1'b0;
        end
    end

    assign bus.send_val = r_full;
    assign bus.send_msg = r_msg;
    assign bus.send_src = r_src;
endmodule
